// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one access per handshake, word-addressed data port
// with byte-lane masks, formatted load results and one-cycle error pulses.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_bmask_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mem_data_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic       we;
        logic [2:0] f3;
        logic [1:0] lo;
    } req_t;

    state_t          state, state_n;
    req_t            rq;
    logic [CW-1:0]   cnt;
    logic            accept, illegal, misaligned, tmo;
    logic [3:0]      lane_mask;
    logic [3:0][7:0] lane_wd;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [31:0]     ld_fmt;

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign mem_req_o   = (state == ACCESS);
    assign mem_we_o    = mem_req_o & rq.we;
    assign done_o      = (state == RESP);

    assign illegal    = req_we_i ? (req_funct3_i > 3'd2)
                                 : (req_funct3_i == 3'd3 || req_funct3_i[2:1] == 2'b11);
    assign misaligned = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                        (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);

    // An ack in the final allowed cycle still completes normally.
    assign tmo = (state == ACCESS) && !mem_ack_i && (cnt == CW'(TIMEOUT - 1));

    // Per byte lane: enable and store data replicated into that lane.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam logic [1:0] L = 2'(k);
        assign lane_mask[k] = (req_funct3_i[1:0] == 2'b00) ? (req_addr_i[1:0] == L) :
                              (req_funct3_i[1:0] == 2'b01) ? (req_addr_i[1] == L[1]) : 1'b1;
        assign lane_wd[k]   = (req_funct3_i[1:0] == 2'b00) ? req_wdata_i[7:0] :
                              (req_funct3_i[1:0] == 2'b01) ? req_wdata_i[8*(k%2) +: 8] :
                                                             req_wdata_i[8*k +: 8];
    end

    always_comb begin
        ld_b = mem_rdata_i[7:0];
        case (rq.lo)
            2'd1:    ld_b = mem_rdata_i[15:8];
            2'd2:    ld_b = mem_rdata_i[23:16];
            2'd3:    ld_b = mem_rdata_i[31:24];
            default: ld_b = mem_rdata_i[7:0];
        endcase
        ld_h = rq.lo[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (rq.f3)
            3'b000:  ld_fmt = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_fmt = {24'd0, ld_b};
            3'b001:  ld_fmt = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_fmt = {16'd0, ld_h};
            default: ld_fmt = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept && !illegal && !misaligned) state_n = ACCESS;
            ACCESS:  if (mem_ack_i) state_n = RESP;
                     else if (tmo)  state_n = IDLE;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rq          <= '0;
            cnt         <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_bmask_o <= '0;
            mem_data_o  <= '0;
            err_o       <= 1'b0;
            err_code_o  <= 2'b00;
        end else begin
            err_o <= 1'b0;
            if (accept) begin
                rq          <= '{we: req_we_i, f3: req_funct3_i, lo: req_addr_i[1:0]};
                cnt         <= '0;
                mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                mem_wdata_o <= lane_wd;
                mem_bmask_o <= lane_mask;
                if (illegal) begin
                    err_o      <= 1'b1;
                    err_code_o <= 2'b10;
                end else if (misaligned) begin
                    err_o      <= 1'b1;
                    err_code_o <= 2'b01;
                end
            end
            if (state == ACCESS) begin
                if (mem_ack_i) begin
                    if (!rq.we) mem_data_o <= ld_fmt;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (tmo) begin
                        err_o      <= 1'b1;
                        err_code_o <= 2'b11;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses queued at issue time,
// popped and compared when done_o/err_o appears.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        req_ready, mem_req, mem_we, done, err;
    logic [31:0] mem_addr, mem_wdata, mem_data;
    logic [3:0]  mem_bmask;
    logic [1:0]  err_code;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    logic [31:0] last_data = 32'd0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_bmask_o(mem_bmask), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .mem_data_o(mem_data), .done_o(done),
        .err_o(err), .err_code_o(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 1);
        chk({tag, "_req"},   32'(mem_req), 0);
        chk({tag, "_we"},    32'(mem_we), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_err"},   32'(err), 0);
        chk({tag, "_data"},  mem_data, 0);
        chk({tag, "_addr"},  mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_bmask"}, 32'(mem_bmask), 0);
        chk({tag, "_code"},  32'(err_code), 0);
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
        chk("ready_at_issue", 32'(req_ready), 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_AAAA;
    endtask

    task automatic collect(input string tag);
        int   n = 0;
        exp_t e;
        while (!(done || err) && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_resp_seen"}, 32'(done | err), 1);
        if (!(done || err)) return;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_kind"}, 32'({done, err}), e.is_err ? 32'd1 : 32'd2);
        if (e.is_err) chk({tag, "_code"}, 32'(err_code), 32'(e.code));
        else          chk({tag, "_data"}, mem_data, e.data);
    endtask

    // Legal access: ack after 'waits' idle ACCESS cycles, then check response and return to IDLE.
    task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input logic [3:0] m, input logic [31:0] wexp,
                        input logic [31:0] dexp);
        sb.push_back('{is_err: 1'b0, code: 2'b00, data: dexp});
        send(we, f3, a, wd);
        chk({tag, "_addr"},  mem_addr, {a[31:2], 2'b00});
        chk({tag, "_bmask"}, 32'(mem_bmask), 32'(m));
        if (we) chk({tag, "_wdata"}, mem_wdata, wexp);
        for (int i = 0; i <= waits; i++) begin
            chk({tag, "_req_held"}, 32'(mem_req), 1);
            chk({tag, "_we_held"},  32'(mem_we), 32'(we));
            if (i == waits) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            tick();
            mem_ack = 1'b0;
        end
        collect(tag);
        tick();
        chk({tag, "_done_once"}, 32'(done), 0);
        chk({tag, "_ready_back"}, 32'(req_ready), 1);
        last_data = dexp;
    endtask

    // Rejected access: error pulse one cycle after issue, no memory request; leaves bench in the error cycle.
    task automatic err_case(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [1:0] code);
        sb.push_back('{is_err: 1'b1, code: code, data: 32'd0});
        send(we, f3, a, 32'h1234_5678);
        chk({tag, "_noreq"}, 32'(mem_req), 0);
        chk({tag, "_ready"}, 32'(req_ready), 1);
        collect(tag);
    endtask

    initial begin
        #2;
        chk_reset("rst0");
        tick();
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(req_ready), 1);

        xfer("lb",  1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 4'b1000, 32'd0, 32'hFFFF_FF80);
        xfer("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 4'b1000, 32'd0, 32'h0000_0080);
        xfer("sh",  1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'hCAFE_F00D, 3, 4'b1100,
             32'hBEEF_BEEF, last_data);
        xfer("lh",  1'b0, 3'b001, 32'h0000_5002, 32'd0, 32'h8001_7FFF, 1, 4'b1100, 32'd0, 32'hFFFF_8001);
        xfer("lhu", 1'b0, 3'b101, 32'h0000_5000, 32'd0, 32'h8001_8FFF, 0, 4'b0011, 32'd0, 32'h0000_8FFF);
        xfer("sb",  1'b1, 3'b000, 32'h0000_6001, 32'h1234_56A5, 32'd0, 0, 4'b0010,
             32'hA5A5_A5A5, last_data);
        xfer("sw",  1'b1, 3'b010, 32'h0000_6004, 32'h0BAD_F00D, 32'd0, 2, 4'b1111,
             32'h0BAD_F00D, last_data);

        err_case("lw_mis",   1'b0, 3'b010, 32'h0000_3001, 2'b01);
        err_case("ld011",    1'b0, 3'b011, 32'h0000_3001, 2'b10);
        err_case("sh_mis",   1'b1, 3'b001, 32'h0000_3003, 2'b01);
        err_case("st100",    1'b1, 3'b100, 32'h0000_3000, 2'b10);
        err_case("ld110",    1'b0, 3'b110, 32'h0000_3000, 2'b10);
        tick();
        chk("err_pulse_end", 32'(err), 0);
        chk("err_code_hold", 32'(err_code), 32'd2);
        chk("err_noreq", 32'(mem_req), 0);

        sb.push_back('{is_err: 1'b1, code: 2'b11, data: 32'd0});
        send(1'b0, 3'b010, 32'h0000_4000, 32'd0);
        for (int i = 0; i < TO; i++) begin
            chk("tmo_req_high", 32'(mem_req), 1);
            tick();
        end
        chk("tmo_req_drop", 32'(mem_req), 0);
        collect("tmo");
        tick();
        chk("tmo_err_end", 32'(err), 0);
        chk("tmo_idle", 32'(req_ready), 1);
        chk("tmo_code_hold", 32'(err_code), 32'd3);
        chk("tmo_data_hold", mem_data, last_data);

        xfer("tmo_ack", 1'b0, 3'b010, 32'h0000_4004, 32'd0, 32'hDEAD_BEEF, TO - 1, 4'b1111,
             32'd0, 32'hDEAD_BEEF);

        send(1'b0, 3'b010, 32'h0000_7000, 32'd0);
        chk("mid_req_up", 32'(mem_req), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        last_data = 32'd0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_nodone", 32'(done), 0);
            chk("post_rst_noerr", 32'(err), 0);
            tick();
        end
        xfer("after_rst", 1'b0, 3'b100, 32'h0000_7001, 32'd0, 32'h0000_9C00, 0, 4'b0010,
             32'd0, 32'h0000_009C);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
